// File: rtl/serial_subtractor_n.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_n
// Description : Digit-serial N-bit subtractor, diff = a - b - bin, LSB first.
// Revision    : 1.0
// ============================================================================
module serial_subtractor_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int c_N  = WIDTH / DIGIT;
    localparam int c_CW = $clog2(c_N) + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_err
            $error("serial_subtractor_n: DIGIT must divide WIDTH and satisfy 1 <= DIGIT <= WIDTH");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_zero;

    logic [DIGIT-1:0] w_digit;
    logic             w_slice_bout;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;

    // Ripple the borrow through the low DIGIT bits of the operand shifters.
    always_comb begin
        logic v_br;
        v_br    = r_br;
        w_digit = '0;
        for (int i = 0; i < DIGIT; i++) begin
            w_digit[i] = r_a[i] ^ r_b[i] ^ v_br;
            v_br       = (~r_a[i] & r_b[i]) | (~r_a[i] & v_br) | (r_b[i] & v_br);
        end
        w_slice_bout = v_br;
    end

    generate
        if (DIGIT == WIDTH) begin : g_res_full
            assign w_res_next = w_digit;
        end else begin : g_res_shift
            assign w_res_next = {w_digit, r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign w_last = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state <= c_RUN;
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_RUN: begin
                    r_br  <= w_slice_bout;
                    r_res <= w_res_next;
                    r_a   <= r_a >> DIGIT;
                    r_b   <= r_b >> DIGIT;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= c_DONE;
                        r_diff  <= w_res_next;
                        r_bout  <= w_slice_bout;
                        r_zero  <= (w_res_next == '0);
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy = (r_state == c_RUN);
    assign done = (r_state == c_DONE);
    assign diff = r_diff;
    assign bout = r_bout;
    assign zero = r_zero;

endmodule
`default_nettype wire

// File: doc/serial_subtractor_n.md
# serial_subtractor_n

Parametrised, multi-cycle N-bit subtractor that computes diff = a − b − bin using a DIGIT-bit full-subtractor slice. Each clock it consumes DIGIT bits LSB-first and carries the borrow between cycles in a register. It sits beside the single-bit gate-level full subtractor in the arithmetic library. It is the area-cheap choice for wide operands where throughput is not critical. A start/busy/done handshake frames each operation; results are held stable until the next accepted start.

## Interface
- WIDTH, 8, operand and result width in bits; ≥ 1.
- DIGIT, 1, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH; WIDTH % DIGIT == 0 (elaboration error otherwise).
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled on rising edge; accepted only when busy == 0.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; diff/bout/zero are valid from this cycle.
- diff  output  WIDTH  result a − b − bin, modulo 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b + bin (unsigned).
- zero  output  1  1 iff diff == 0; updated together with diff.

## Operation
- N = WIDTH/DIGIT digit cycles per operation; counter width is clog2(N)+1 bits or more.
- States:
  - IDLE: busy = 0.
  - RUN: busy = 1.
  - DONE: busy = 0, done = 1, lasts exactly one cycle.
- Transitions:
  - IDLE→RUN on start.
  - RUN→RUN while digits remain.
  - RUN→DONE on the edge that processes digit N−1.
  - DONE→RUN if start is high in the DONE cycle (back-to-back).
  - DONE→IDLE otherwise.
- On accept:
  - Load a and b into shift registers.
  - Borrow register ← bin.
  - Digit counter ← 0.
- Each RUN edge, for digit k (bits k·DIGIT .. k·DIGIT+DIGIT−1):
  - Ripple full-subtract DIGIT bits using the per-bit rule:
    - d = x ^ y ^ br.
    - br' = (~x & y) | (~x & br) | (y & br).
  - The borrow register takes the slice borrow-out.
  - Shift the digit into the result register from the MSB side.
  - Shift the operands right by DIGIT.
- On the RUN→DONE edge:
  - diff ← completed result.
  - bout ← final borrow.
  - zero ← (result == 0).
- diff, bout and zero change only on RUN→DONE edges. They hold otherwise, including while busy for a following operation.
- start while busy == 1 is ignored; a, b and bin are not resampled.
- Reset (rst_n low at an edge), from any state including mid-RUN:
  - State → IDLE.
  - busy, done, diff, bout and zero → 0.
  - The counter and borrow register clear.
  - The in-flight operation is discarded, with no done pulse.
- With start held high continuously, a new operation begins on every DONE cycle.

## Timing
- Edge E0 samples start = 1 in IDLE; busy = 1 from E0.
- done = 1 and results valid in the cycle after edge E0+N.
- Latency, start edge to done: N cycles. For WIDTH = 8: N = 8 with DIGIT = 1; N = 2 with DIGIT = 4; N = 1 with DIGIT = WIDTH.
- Back-to-back throughput: one result per N+1 cycles with IDLE skipped. done is never high in two consecutive cycles.
- busy and done are never both 1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH = 8, DIGIT = 1:
  - Stimulus: a = 0x5A, b = 0x3C, bin = 0.
  - Response: done 8 cycles after start; diff = 0x1E, bout = 0, zero = 0.
- WIDTH = 8, DIGIT = 1, wrap-around:
  - Stimulus: a = 0x00, b = 0x01, bin = 0.
  - Response: diff = 0xFF, bout = 1.
  - Repeat with a = 0x10, b = 0x0F, bin = 1 → diff = 0x00, zero = 1, bout = 0.
- WIDTH = 8, DIGIT = 4:
  - Exhaustive 2^17 combinations of a, b, bin against the golden model (a − b − bin) mod 256 and borrow.
  - Latency is exactly 2 cycles; DIGIT = 1 is also run exhaustively.
- Start held high across 3 operations:
  - Required: done pulses spaced N+1 cycles apart; each result matches its operands.
  - Required: start pulses during busy are ignored, and the operand changes they carry do not affect the result.
- Reset mid-operation:
  - Stimulus: rst_n low for 1 cycle at RUN digit 3 of 8.
  - Response: busy, done, diff, bout and zero all 0 on the next cycle, and no done follows.
  - Response: a fresh start afterwards gives a correct result.
- Parameter corners: WIDTH = 1, DIGIT = 1, all 8 single-bit input combinations.
  - Response: diff and bout equal the single-bit full-subtractor truth table.
  - Examples: a = 0, b = 1, bin = 1 → diff = 0, bout = 1. a = 1, b = 0, bin = 0 → diff = 1, bout = 0.
